// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller shared by instruction fetch and the MEM stage.
// Arbitrates the two requesters and serialises 1/2/4-byte accesses little-endian.
module mem_ctrl #(
  parameter int unsigned RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [31:0]        addr_sum;
  logic [31-RAM_AW:0] unused_addr_hi;
  logic [1:0]         rd_idx;
  logic [31:0]        rd_mask;

  // Full 32-bit add so the address wraps mod 2^32 before truncation to the RAM width.
  assign addr_sum       = base_q + {29'd0, cnt_q};
  assign unused_addr_hi = addr_sum[31:RAM_AW];
  assign rd_idx         = cnt_q[1:0] - 2'd1;

  always_comb begin
    case (n_q)
      3'd1:    rd_mask = 32'h0000_00ff;
      3'd2:    rd_mask = 32'h0000_ffff;
      default: rd_mask = 32'hffff_ffff;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr    = '0;
    ram_wr      = 1'b0;
    ram_dout    = 8'd0;

    case (state_q)
      S_IDLE: begin
        // A done pulse in flight gives the requester this cycle to drop its request.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            owner_d = OWN_MEM;
            base_d  = mem_addr;
            wdata_d = mem_wdata;
            cnt_d   = 3'd0;
            case (mem_len)
              2'd0:    n_d = 3'd1;
              2'd1:    n_d = 3'd2;
              default: n_d = 3'd4;
            endcase
            state_d = mem_we ? S_WR : S_RD;
          end else if (if_req && !flush) begin
            owner_d = OWN_IF;
            base_d  = if_addr;
            cnt_d   = 3'd0;
            n_d     = 3'd4;
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        if (cnt_q < n_q) ram_addr = addr_sum[RAM_AW-1:0];
        // RAM data lags its address by one cycle, so count k delivers byte k-1.
        if (cnt_q != 3'd0) rbuf_d[{rd_idx, 3'b000} +: 8] = ram_din;
        cnt_d = cnt_q + 3'd1;
        if (owner_q == OWN_IF && flush) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == n_q) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          if (owner_q == OWN_IF) begin
            if_done_d = 1'b1;
            if_data_d = rbuf_d & rd_mask;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = rbuf_d & rd_mask;
          end
        end
      end

      S_WR: begin
        ram_addr = addr_sum[RAM_AW-1:0];
        ram_wr   = 1'b1;
        ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == n_q - 3'd1) begin
          state_d    = S_IDLE;
          cnt_d      = 3'd0;
          mem_done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule
